// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state types, ASCII constants and baud divider helper
// WIN_ANNOUNCER_PARITY_EN adds the PARITY serialiser state.
package uart_pkg;

  typedef enum logic [1:0] {
    TOP_IDLE,
    TOP_LOAD,
    TOP_SEND,
    TOP_DONE
  } top_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START_BIT,
    TX_DATA,
`ifdef WIN_ANNOUNCER_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  localparam logic [7:0] CR  = 8'h0D;
  localparam logic [7:0] LF  = 8'h0A;
  localparam logic [7:0] NUL = 8'h00;

  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - one-byte UART serialiser, LSB first, 8N1 or 8E1
// WIN_ANNOUNCER_PARITY_EN inserts an even-parity bit between data and stop.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       frame_done,
  output logic       tx
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  tx_state_t     state, state_next;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          baud_tc;
`ifdef WIN_ANNOUNCER_PARITY_EN
  logic          parity;
`endif

  assign baud_tc    = (baud_cnt == BW'(BAUD_DIV - 1));
  assign byte_ready = (state == TX_IDLE);
  // Lets the caller reload on the very edge the stop bit ends, keeping the gap to one clock.
  assign frame_done = (state == TX_STOP) && baud_tc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= TX_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      TX_IDLE:      if (byte_valid) state_next = TX_START_BIT;
      TX_START_BIT: if (baud_tc) state_next = TX_DATA;
`ifdef WIN_ANNOUNCER_PARITY_EN
      TX_DATA:      if (baud_tc && bit_cnt == 3'd7) state_next = TX_PARITY;
      TX_PARITY:    if (baud_tc) state_next = TX_STOP;
`else
      TX_DATA:      if (baud_tc && bit_cnt == 3'd7) state_next = TX_STOP;
`endif
      TX_STOP:      if (baud_tc) state_next = TX_IDLE;
      default:      state_next = TX_IDLE;
    endcase
  end

  // tx is loaded with the level of the bit being entered, so it changes on the same edge as state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
`ifdef WIN_ANNOUNCER_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      if (state == TX_IDLE || baud_tc) baud_cnt <= '0;
      else                             baud_cnt <= baud_cnt + 1'b1;
      case (state)
        TX_IDLE: begin
          bit_cnt <= '0;
          if (byte_valid) begin
            shift_reg <= byte_data;
            tx        <= 1'b0;
`ifdef WIN_ANNOUNCER_PARITY_EN
            parity    <= ^byte_data;
`endif
          end else begin
            tx <= 1'b1;
          end
        end
        TX_START_BIT: if (baud_tc) tx <= shift_reg[0];
        TX_DATA: begin
          if (baud_tc) begin
            bit_cnt   <= bit_cnt + 1'b1;
            shift_reg <= {1'b0, shift_reg[7:1]};
`ifdef WIN_ANNOUNCER_PARITY_EN
            if (bit_cnt == 3'd7) tx <= parity;
`else
            if (bit_cnt == 3'd7) tx <= 1'b1;
`endif
            else                 tx <= shift_reg[1];
          end
        end
`ifdef WIN_ANNOUNCER_PARITY_EN
        TX_PARITY: if (baud_tc) tx <= 1'b1;
`endif
        TX_STOP: tx <= 1'b1;
        default: tx <= 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/uart_win_announcer.sv
// rtl/uart_win_announcer.sv - sends a fixed ROM message over UART on each accepted start pulse
// WIN_ANNOUNCER_PARITY_EN selects 8E1 framing in the serialiser.
module uart_win_announcer
  import uart_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int BAUD    = 9600,
  parameter int MSG_MAX = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] msg_index,
  output logic       tx,
  output logic       busy,
  output logic       done_tick
);

  localparam int BAUD_DIV = baud_div(CLK_HZ, BAUD);
  localparam int PW       = $clog2(MSG_MAX + 1);

  top_state_t    state, state_next;
  logic [3:0]    msg_q;
  logic [PW-1:0] char_ptr;
  logic [7:0]    rom_byte;
  logic          msg_end;
  logic          byte_valid;
  logic          byte_ready;
  logic          frame_done;
  int            ptr_i;

  assign ptr_i = int'(char_ptr);

  always_comb begin
    rom_byte = NUL;
    case (msg_q)
      4'd0, 4'd1: begin
        case (ptr_i)
          0:       rom_byte = 8'h50;
          1:       rom_byte = (msg_q == 4'd0) ? 8'h31 : 8'h32;
          2:       rom_byte = 8'h20;
          3:       rom_byte = 8'h57;
          4:       rom_byte = 8'h49;
          5:       rom_byte = 8'h4E;
          6:       rom_byte = 8'h53;
          7:       rom_byte = CR;
          8:       rom_byte = LF;
          default: rom_byte = NUL;
        endcase
      end
      4'd2: begin
        case (ptr_i)
          0:       rom_byte = 8'h53;
          1:       rom_byte = 8'h54;
          2:       rom_byte = 8'h41;
          3:       rom_byte = 8'h52;
          4:       rom_byte = 8'h54;
          5:       rom_byte = CR;
          6:       rom_byte = LF;
          default: rom_byte = NUL;
        endcase
      end
      default: begin
        case (ptr_i)
          0:       rom_byte = 8'h3F;
          1:       rom_byte = CR;
          2:       rom_byte = LF;
          default: rom_byte = NUL;
        endcase
      end
    endcase
  end

  assign msg_end = (rom_byte == NUL) || (char_ptr == PW'(MSG_MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= TOP_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    byte_valid = 1'b0;
    case (state)
      TOP_IDLE: if (start) state_next = TOP_LOAD;
      TOP_LOAD: begin
        if (msg_end) begin
          state_next = TOP_DONE;
        end else if (byte_ready) begin
          byte_valid = 1'b1;
          state_next = TOP_SEND;
        end
      end
      TOP_SEND: if (frame_done) state_next = TOP_LOAD;
      TOP_DONE: state_next = TOP_IDLE;
      default:  state_next = TOP_IDLE;
    endcase
  end

  // msg_index is only captured in IDLE, so requests while a message is out are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msg_q    <= '0;
      char_ptr <= '0;
    end else if (state == TOP_IDLE && start) begin
      msg_q    <= msg_index;
      char_ptr <= '0;
    end else if (state == TOP_SEND && frame_done) begin
      char_ptr <= char_ptr + 1'b1;
    end
  end

  assign busy      = (state == TOP_LOAD) || (state == TOP_SEND);
  assign done_tick = (state == TOP_DONE);

  uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx_byte (
    .clk        (clk),
    .reset      (reset),
    .byte_data  (rom_byte),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .frame_done (frame_done),
    .tx         (tx)
  );

endmodule

// File: tb/tb_uart_win_announcer.sv
// tb/tb_uart_win_announcer.sv - directed self-checking bench with a UART receive model
module tb_uart_win_announcer;

  localparam int BD = 16;
`ifdef WIN_ANNOUNCER_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * BD;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] msg_index = 4'd0;
  logic       tx;
  logic       busy;
  logic       done_tick;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  logic [7:0] rx_q[$];
  logic       rx_par_q[$];
  int         rx_err = 0;
  logic       rx_active = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = 8'h00;

  uart_win_announcer #(
    .CLK_HZ  (16),
    .BAUD    (1),
    .MSG_MAX (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .msg_index (msg_index),
    .tx        (tx),
    .busy      (busy),
    .done_tick (done_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Receiver samples each bit near its centre, counting negedges from the detected start edge.
  always @(negedge clk) begin
    if (reset) begin
      rx_active <= 1'b0;
    end else if (!rx_active) begin
      if (tx === 1'b0) begin
        rx_active <= 1'b1;
        rx_cnt    <= 1;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt % BD == BD / 2) begin
        if (rx_cnt / BD == 0) begin
          if (tx !== 1'b0) begin
            rx_err    <= rx_err + 1;
            rx_active <= 1'b0;
          end
        end else if (rx_cnt / BD <= 8) begin
          rx_sh[rx_cnt / BD - 1] <= tx;
        end else if (rx_cnt / BD < NBITS - 1) begin
          rx_par_q.push_back(tx);
        end else begin
          if (tx !== 1'b1) rx_err <= rx_err + 1;
          rx_q.push_back(rx_sh);
          rx_active <= 1'b0;
        end
      end
    end
  end

  task automatic run_msg(input logic [3:0] m, input int inj_at, input logic [3:0] inj_m,
                         output int t0, output int t_fall, output int t_done,
                         output int n_done, output logic busy_first);
    rx_q.delete();
    rx_par_q.delete();
    rx_err  = 0;
    t_fall  = -1;
    t_done  = -1;
    n_done  = 0;
    msg_index = m;
    start   = 1'b1;
    t0      = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    busy_first = busy;
    for (int i = 0; i < 4000; i++) begin
      if (tx === 1'b0 && t_fall < 0) t_fall = cyc;
      if (done_tick === 1'b1) begin
        n_done++;
        if (t_done < 0) t_done = cyc;
      end
      if (t_done >= 0 && cyc >= t_done + 24) break;
      if (inj_at > 0 && cyc == t0 + inj_at) begin
        start = 1'b1;
        msg_index = inj_m;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    int bad_tx = 0, bad_busy = 0, bad_done = 0;
    reset = 1'b1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_total++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (done_tick !== 1'b0) $display("FAIL reset_done: got %b want 0", done_tick); else n_pass++;
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
      if (done_tick !== 1'b0) bad_done++;
    end
    n_total++; if (bad_tx != 0) $display("FAIL idle_tx: got %0d bad cycles want 0", bad_tx); else n_pass++;
    n_total++; if (bad_busy != 0) $display("FAIL idle_busy: got %0d bad cycles want 0", bad_busy); else n_pass++;
    n_total++; if (bad_done != 0) $display("FAIL idle_done: got %0d bad cycles want 0", bad_done); else n_pass++;
  endtask

  task automatic test_msg0();
    logic [7:0] exp_b [9] = '{8'h50, 8'h31, 8'h20, 8'h57, 8'h49, 8'h4E, 8'h53, 8'h0D, 8'h0A};
    int t0, t_fall, t_done, n_done;
    logic b1;
    logic [7:0] got;
    run_msg(4'd0, 0, 4'd0, t0, t_fall, t_done, n_done, b1);
    n_total++; if (b1 !== 1'b1) $display("FAIL msg0_busy_start: got %b want 1", b1); else n_pass++;
    n_total++; if (t_fall != t0 + 2) $display("FAIL msg0_tx_fall: got %0d want %0d", t_fall - t0, 2); else n_pass++;
    n_total++; if (t_done != t0 + 9 * (FRAME + 1) + 2)
      $display("FAIL msg0_done_time: got %0d want %0d", t_done - t0, 9 * (FRAME + 1) + 2); else n_pass++;
    n_total++; if (n_done != 1) $display("FAIL msg0_done_count: got %0d want 1", n_done); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL msg0_busy_end: got %b want 0", busy); else n_pass++;
    n_total++; if (rx_err != 0) $display("FAIL msg0_frame_err: got %0d want 0", rx_err); else n_pass++;
    n_total++; if (rx_q.size() != 9) $display("FAIL msg0_len: got %0d want 9", rx_q.size()); else n_pass++;
    for (int i = 0; i < 9; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      n_total++; if (got !== exp_b[i]) $display("FAIL msg0_byte%0d: got %h want %h", i, got, exp_b[i]); else n_pass++;
    end
`ifdef WIN_ANNOUNCER_PARITY_EN
    n_total++; if (rx_par_q.size() != 9) $display("FAIL par_len: got %0d want 9", rx_par_q.size()); else n_pass++;
    got = {7'd0, (rx_par_q.size() > 0) ? rx_par_q[0] : 1'bx};
    n_total++; if (got !== 8'd0) $display("FAIL par_P: got %h want 0", got); else n_pass++;
    got = {7'd0, (rx_par_q.size() > 3) ? rx_par_q[3] : 1'bx};
    n_total++; if (got !== 8'd1) $display("FAIL par_W: got %h want 1", got); else n_pass++;
`endif
  endtask

  task automatic test_msg1_and_default();
    logic [7:0] exp1 [9] = '{8'h50, 8'h32, 8'h20, 8'h57, 8'h49, 8'h4E, 8'h53, 8'h0D, 8'h0A};
    logic [7:0] exp9 [3] = '{8'h3F, 8'h0D, 8'h0A};
    int t0, t_fall, t_done, n_done;
    logic b1;
    logic [7:0] got;
    run_msg(4'd1, 0, 4'd0, t0, t_fall, t_done, n_done, b1);
    n_total++; if (rx_q.size() != 9) $display("FAIL msg1_len: got %0d want 9", rx_q.size()); else n_pass++;
    for (int i = 0; i < 9; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      n_total++; if (got !== exp1[i]) $display("FAIL msg1_byte%0d: got %h want %h", i, got, exp1[i]); else n_pass++;
    end
    repeat (3) @(posedge clk);
    #1;
    run_msg(4'd9, 0, 4'd0, t0, t_fall, t_done, n_done, b1);
    n_total++; if (rx_q.size() != 3) $display("FAIL msg9_len: got %0d want 3", rx_q.size()); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      n_total++; if (got !== exp9[i]) $display("FAIL msg9_byte%0d: got %h want %h", i, got, exp9[i]); else n_pass++;
    end
    n_total++; if (t_done != t0 + 3 * (FRAME + 1) + 2)
      $display("FAIL msg9_done_time: got %0d want %0d", t_done - t0, 3 * (FRAME + 1) + 2); else n_pass++;
  endtask

  task automatic test_start_while_busy();
    logic [7:0] exp1 [9] = '{8'h50, 8'h32, 8'h20, 8'h57, 8'h49, 8'h4E, 8'h53, 8'h0D, 8'h0A};
    int t0, t_fall, t_done, n_done;
    logic b1;
    logic [7:0] got;
    repeat (3) @(posedge clk);
    #1;
    run_msg(4'd1, 2 + 3 * (FRAME + 1) + 20, 4'd2, t0, t_fall, t_done, n_done, b1);
    n_total++; if (n_done != 1) $display("FAIL busy_done_count: got %0d want 1", n_done); else n_pass++;
    n_total++; if (rx_q.size() != 9) $display("FAIL busy_len: got %0d want 9", rx_q.size()); else n_pass++;
    for (int i = 0; i < 9; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      n_total++; if (got !== exp1[i]) $display("FAIL busy_byte%0d: got %h want %h", i, got, exp1[i]); else n_pass++;
    end
    n_total++; if (busy !== 1'b0) $display("FAIL busy_after_drop: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] exp2 [7] = '{8'h53, 8'h54, 8'h41, 8'h52, 8'h54, 8'h0D, 8'h0A};
    int t0, t_fall, t_done, n_done;
    logic b1;
    logic [7:0] got;
    repeat (3) @(posedge clk);
    #1;
    msg_index = 4'd0;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    // Middle of data bit 2 of 'I' (0x49), which is a 0 on the line.
    while (cyc < t0 + 2 + 4 * (FRAME + 1) + BD + 2 * BD + BD / 2) begin
      @(posedge clk); #1;
    end
    n_total++; if (tx !== 1'b0) $display("FAIL midframe_tx_before: got %b want 0", tx); else n_pass++;
    reset = 1'b1;
    #1;
    n_total++; if (tx !== 1'b1) $display("FAIL midframe_tx_reset: got %b want 1", tx); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL midframe_busy_reset: got %b want 0", busy); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_msg(4'd2, 0, 4'd0, t0, t_fall, t_done, n_done, b1);
    n_total++; if (rx_q.size() != 7) $display("FAIL after_reset_len: got %0d want 7", rx_q.size()); else n_pass++;
    for (int i = 0; i < 7; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      n_total++; if (got !== exp2[i]) $display("FAIL after_reset_byte%0d: got %h want %h", i, got, exp2[i]); else n_pass++;
    end
    n_total++; if (t_done != t0 + 7 * (FRAME + 1) + 2)
      $display("FAIL after_reset_done_time: got %0d want %0d", t_done - t0, 7 * (FRAME + 1) + 2); else n_pass++;
    n_total++; if (rx_err != 0) $display("FAIL after_reset_frame_err: got %0d want 0", rx_err); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_msg0();
    test_msg1_and_default();
    test_start_while_busy();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
